// File: rtl/trig_fanout_gen.sv
// trig_fanout_gen: multi-channel trigger burst generator with per-channel delay/count/period/width.
// Define TRIG_ERR_CNT_EN to build the saturating rejected-start counter on O_Err_cnt.
module trig_fanout_gen #(
    parameter int CH_NUM = 17,
    parameter int CNT_W  = 32,
    parameter int PW_W   = 8
) (
    input  logic              I_clk,
    input  logic              I_Rst_n,
    input  logic              I_Trig_in,
    input  logic              I_Abort,
    input  logic [CH_NUM-1:0] I_Ch_en,
    input  logic              I_Cfg_wr,
    input  logic [4:0]        I_Cfg_ch,
    input  logic [CNT_W-1:0]  I_Cfg_delay,
    input  logic [CNT_W-1:0]  I_Cfg_num,
    input  logic [CNT_W-1:0]  I_Cfg_step,
    input  logic [PW_W-1:0]   I_Cfg_width,
    output logic [CH_NUM-1:0] O_Trig,
    output logic              O_Busy,
    output logic              O_Done,
    output logic              O_Err,
    output logic [15:0]       O_Err_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic              trig_in_q, start_q, busy_q, done_q, err_q;
    logic [CH_NUM-1:0] trig_q, trig_d, run_d;
    logic              rise, accept, err_d, busy_d, done_d, cfg_hit;

    assign rise    = I_Trig_in & ~trig_in_q;
    assign accept  = rise & ~busy_q & ~start_q & ~I_Abort;
    assign err_d   = rise & (busy_q | start_q) & ~I_Abort;
    assign busy_d  = ~I_Abort & (start_q | (|run_d));
    assign done_d  = busy_q & ~busy_d & ~I_Abort;
    assign cfg_hit = I_Cfg_wr & ({1'b0, I_Cfg_ch} < 6'(CH_NUM));

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [CNT_W-1:0] delay_q, num_q, step_q;
        logic [PW_W-1:0]  width_q;
        logic [CNT_W-1:0] a_delay_q, a_num_q, a_gap_q;
        logic [PW_W-1:0]  a_w_q;
        logic             a_en_q;
        logic [1:0]       st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, ncnt_q, ncnt_d;
        logic [PW_W-1:0]  wcnt_q, wcnt_d;
        logic [PW_W-1:0]  w;
        logic [CNT_W-1:0] wx, per;
        // Period is clamped so at least one low cycle separates pulses.
        assign w   = (width_q == '0) ? PW_W'(1) : width_q;
        assign wx  = CNT_W'(w);
        assign per = (step_q > wx) ? step_q : wx + CNT_W'(1);
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            ncnt_d = ncnt_q;
            wcnt_d = wcnt_q;
            if (I_Abort) st_d = S_IDLE;
            else case (st_q)
                S_IDLE: if (start_q && a_en_q) begin
                    ncnt_d = a_num_q - CNT_W'(1);
                    st_d   = (a_delay_q == '0) ? S_HIGH : S_DELAY;
                    wcnt_d = a_w_q - PW_W'(1);
                    cnt_d  = a_delay_q - CNT_W'(1);
                end
                S_DELAY, S_GAP: begin
                    st_d   = (cnt_q == '0) ? S_HIGH : st_q;
                    wcnt_d = a_w_q - PW_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                end
                default: if (wcnt_q == '0) begin
                    st_d   = (ncnt_q == '0) ? S_IDLE : S_GAP;
                    cnt_d  = a_gap_q - CNT_W'(1);
                    ncnt_d = ncnt_q - CNT_W'(1);
                end else wcnt_d = wcnt_q - PW_W'(1);
            endcase
        end
        assign run_d[c]  = st_d != S_IDLE;
        assign trig_d[c] = st_d == S_HIGH;
        always_ff @(posedge I_clk or negedge I_Rst_n) begin
            if (!I_Rst_n) begin
                delay_q   <= '0;
                num_q     <= CNT_W'(1);
                step_q    <= CNT_W'(2);
                width_q   <= PW_W'(1);
                a_delay_q <= '0;
                a_num_q   <= '0;
                a_gap_q   <= '0;
                a_w_q     <= '0;
                a_en_q    <= 1'b0;
                st_q      <= S_IDLE;
                cnt_q     <= '0;
                ncnt_q    <= '0;
                wcnt_q    <= '0;
            end else begin
                if (cfg_hit && I_Cfg_ch == 5'(c)) begin
                    delay_q <= I_Cfg_delay;
                    num_q   <= I_Cfg_num;
                    step_q  <= I_Cfg_step;
                    width_q <= I_Cfg_width;
                end
                if (accept) begin
                    a_delay_q <= delay_q;
                    a_num_q   <= num_q;
                    a_gap_q   <= per - wx;
                    a_w_q     <= w;
                    a_en_q    <= I_Ch_en[c] & (num_q != '0);
                end
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                ncnt_q <= ncnt_d;
                wcnt_q <= wcnt_d;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            trig_in_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            trig_q    <= '0;
        end else begin
            trig_in_q <= I_Trig_in;
            start_q   <= accept;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            trig_q    <= trig_d;
        end
    end

`ifdef TRIG_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge I_clk or negedge I_Rst_n) begin
        if (!I_Rst_n) err_cnt_q <= '0;
        else if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign O_Err_cnt = err_cnt_q;
`else
    assign O_Err_cnt = '0;
`endif

    assign O_Trig = trig_q;
    assign O_Busy = busy_q;
    assign O_Done = done_q;
    assign O_Err  = err_q;
endmodule

// File: doc/trig_fanout_gen.md
TRIG_FANOUT_GEN -- requirements
Module: trig_fanout_gen

Interface
REQ-001 SHALL have parameter CH_NUM, default 17: number of trigger output channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 32: width of the delay, count and step fields.
REQ-003 SHALL have parameter PW_W, default 8: width of the pulse-width field.
REQ-004 I_clk  in  1  single clock for all logic; one clock, no other clock domains.
REQ-005 I_Rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 I_Trig_in  in  1  burst start request; acts on its rising edge.
REQ-007 I_Abort  in  1  synchronous abort of the running burst.
REQ-008 I_Ch_en  in  CH_NUM  per-channel enable, sampled at burst start.
REQ-009 I_Cfg_wr  in  1  configuration write strobe.
REQ-010 I_Cfg_ch  in  5  channel index of the write.
REQ-011 I_Cfg_delay / I_Cfg_num / I_Cfg_step  in  CNT_W each  first-pulse delay, pulse count, pulse period.
REQ-012 I_Cfg_width  in  PW_W  pulse high time in cycles.
REQ-013 O_Trig  out  CH_NUM  registered trigger outputs.
REQ-014 O_Busy  out  1  burst in progress.
REQ-015 O_Done  out  1  one-cycle burst-complete pulse.
REQ-016 O_Err  out  1  one-cycle pulse on a rejected start.
REQ-017 O_Err_cnt  out  16  rejected-start counter.

Function
REQ-018 A cycle with I_Cfg_wr=1 and I_Cfg_ch<CH_NUM SHALL write the four fields of that channel; writes with I_Cfg_ch>=CH_NUM are ignored.
REQ-019 Start: a rising edge of I_Trig_in (high now, low the previous cycle) sampled at clock edge k with O_Busy=0 and I_Abort=0 SHALL be accepted.
REQ-020 On an accepted start, all config fields and I_Ch_en SHALL be copied into active registers; later config writes affect only the next burst.
REQ-021 Each channel SHALL run an FSM: IDLE -> DELAY -> HIGH -> GAP -> HIGH ... -> IDLE.
REQ-022 A channel with enable=0 or num=0 SHALL stay in IDLE and O_Trig[c]=0 for the whole burst.
REQ-023 The first pulse SHALL rise at edge k+1+delay and stay high for max(width,1) cycles.
REQ-024 Pulse n (n=1..num) SHALL rise (n-1)*P cycles after the first, where P=max(step, max(width,1)+1), so a low gap of at least one cycle always exists.
REQ-025 After pulse num falls, the channel SHALL return to IDLE.
REQ-026 Counters SHALL be CNT_W wide; no wrap occurs because delay, step and num are each counted down from the loaded value to 0.
REQ-027 O_Busy SHALL be 1 from edge k+1 until the cycle after every active channel is back in IDLE.
REQ-028 O_Done SHALL pulse for exactly one cycle coincident with O_Busy falling.
REQ-029 A burst in which every channel is inactive SHALL assert O_Busy for 1 cycle, then O_Done.
REQ-030 A rising edge of I_Trig_in while O_Busy=1 SHALL be ignored and SHALL pulse O_Err for one cycle.
REQ-031 I_Abort=1 SHALL force all channels to IDLE, O_Trig=0 and O_Busy=0 at the next edge, with no O_Done.
REQ-032 I_Abort SHALL take priority over a simultaneous start; that start is dropped and does not assert O_Err.

Reset
REQ-033 I_Rst_n=0 SHALL asynchronously clear: O_Trig=0, O_Busy=0, O_Done=0, O_Err=0, O_Err_cnt=0, all FSMs to IDLE, and the edge-detect register to 0.
REQ-034 Reset SHALL set every channel's config to delay=0, num=1, step=2, width=1.
REQ-035 Reset asserted mid-burst SHALL end the burst immediately with no O_Done.

Configuration
REQ-036 Macro TRIG_ERR_CNT_EN defined: O_Err_cnt SHALL increment by 1 on each O_Err pulse, saturating at 16'hFFFF, and clear only on reset.
REQ-037 Macro TRIG_ERR_CNT_EN undefined: O_Err_cnt SHALL be constant 0 and no counter logic is built; O_Err behaviour is unchanged.

Verification
REQ-038 Ch0 set to delay=3, num=4, step=10, width=2, all channels enabled, start at edge k -> O_Trig[0] high at k+4..k+5, k+14..k+15, k+24..k+25, k+34..k+35; O_Done at k+36.
REQ-039 Ch1 set to width=5, step=3 -> period clamped to 6, with 5 cycles high and 1 cycle low per pulse.
REQ-040 Second rising edge of I_Trig_in while busy, with the macro defined -> O_Err pulses once, O_Err_cnt=1, burst timing unchanged.
REQ-041 I_Abort at k+15 during the REQ-038 burst -> O_Trig=0 and O_Busy=0 at k+16, no O_Done; a new start at k+20 is accepted.
REQ-042 I_Ch_en=0 for all channels, or num=0 everywhere -> O_Trig stays 0, O_Busy for 1 cycle, then O_Done.
REQ-043 Config write to ch2 mid-burst, and a write with I_Cfg_ch=31 when CH_NUM=17 -> the running burst is unaffected, the next burst uses the new ch2 values, and the index-31 write has no effect.
